// File: rtl/seven_seg_scan.sv
// Multiplexed hex driver for a DIGITS-wide 7-segment display, scanned by an
// asynchronous divided clock, with a frame-aligned shadow load, leading-zero blanking and an anti-ghost gap.
module seven_seg_scan #(
   parameter int DIGITS         = 4,
   parameter int BLANK_CYCLES   = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clockIN,
   input  logic                  resetIN,
   input  logic                  scanClkIN,
   input  logic                  loadIN,
   input  logic [4*DIGITS-1:0]   valueIN,
   input  logic [DIGITS-1:0]     dpIN,
   input  logic                  blankZeroIN,
   output logic [6:0]            segOUT,
   output logic                  dpOUT,
   output logic [DIGITS-1:0]     anodeOUT,
   output logic                  frameOUT,
   output logic                  pendingOUT
);

   localparam int                IDX_W      = $clog2(DIGITS);
   localparam int                CNT_W      = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0]  BLANK_LOAD = CNT_W'(BLANK_CYCLES);
   localparam logic [6:0]        SEG_OFF    = {7{SEG_ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] AN_OFF     = {DIGITS{AN_ACTIVE_LOW}};

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scanState_e;

   // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
   function automatic logic [6:0] decodeHex(input logic [3:0] nibble);
      logic [6:0] pattern;
      case (nibble)
         4'h0: pattern = 7'b0111111;
         4'h1: pattern = 7'b0000110;
         4'h2: pattern = 7'b1011011;
         4'h3: pattern = 7'b1001111;
         4'h4: pattern = 7'b1100110;
         4'h5: pattern = 7'b1101101;
         4'h6: pattern = 7'b1111101;
         4'h7: pattern = 7'b0000111;
         4'h8: pattern = 7'b1111111;
         4'h9: pattern = 7'b1101111;
         4'hA: pattern = 7'b1110111;
         4'hB: pattern = 7'b1111100;
         4'hC: pattern = 7'b0111001;
         4'hD: pattern = 7'b1011110;
         4'hE: pattern = 7'b1111001;
         default: pattern = 7'b1110001;
      endcase
      return pattern;
   endfunction

   logic                  scanSync1, scanSync2, scanPrev, tickArmed;
   logic                  tick, wrapTick;

   scanState_e            state, stateNext;
   logic [IDX_W-1:0]      idx, idxNext;
   logic [CNT_W-1:0]      counter, counterNext;

   logic [4*DIGITS-1:0]   activeValue, activeNext;
   logic [DIGITS-1:0]     activeDp, activeDpNext;
   logic [4*DIGITS-1:0]   pendingValue, pendingValueNext;
   logic [DIGITS-1:0]     pendingDp, pendingDpNext;
   logic                  pendingNext;

   logic [3:0]            nibble;
   logic [DIGITS-1:0]     zeroAbove;
   logic                  suppress;
   logic [6:0]            segNext;
   logic                  dpNext;
   logic [DIGITS-1:0]     anodeNext;

   // NOTE: synchroniser flops reset high, so a scan clock that is already high
   // at reset release never looks like a rising edge; tickArmed adds an explicit low sighting.
   always_ff @(posedge clockIN or posedge resetIN) begin
      if (resetIN) begin
         scanSync1 <= 1'b1;
         scanSync2 <= 1'b1;
         scanPrev  <= 1'b1;
         tickArmed <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop sees pre-edge values.
         scanSync1 <= scanClkIN;
         scanSync2 <= scanSync1;
         scanPrev  <= scanSync2;
         tickArmed <= tickArmed | ~scanSync2;
      end
   end

   assign tick     = scanSync2 & ~scanPrev & tickArmed;
   assign wrapTick = tick & (idx == LAST_IDX);

   // Scan sequencing: a tick always restarts the blank gap, even inside one.
   always_comb begin
      // NOTE: defaults first in every always_comb so no path leaves a latch behind.
      stateNext   = state;
      idxNext     = idx;
      counterNext = counter;
      if (tick) begin
         idxNext     = (idx == LAST_IDX) ? '0 : idx + 1'b1;
         stateNext   = BLANK;
         counterNext = BLANK_LOAD;
      end else if (state == BLANK) begin
         if (counter == '0) begin
            stateNext = DRIVE;
         end else begin
            counterNext = counter - 1'b1;
         end
      end
   end

   // Shadow load: pending waits for the frame wrap; a load on the wrap itself goes straight to active.
   always_comb begin
      activeNext       = activeValue;
      activeDpNext     = activeDp;
      pendingValueNext = pendingValue;
      pendingDpNext    = pendingDp;
      pendingNext      = pendingOUT;
      if (wrapTick) begin
         pendingNext = 1'b0;
         if (loadIN) begin
            activeNext   = valueIN;
            activeDpNext = dpIN;
         end else if (pendingOUT) begin
            activeNext   = pendingValue;
            activeDpNext = pendingDp;
         end
      end else if (loadIN) begin
         pendingValueNext = valueIN;
         pendingDpNext    = dpIN;
         pendingNext      = 1'b1;
      end
   end

   // Display data for the next cycle, built from next-state values so the
   // registered anode, segments and dp all switch on the same edge.
   always_comb begin
      nibble    = activeNext[{idxNext, 2'b00} +: 4];
      zeroAbove = '0;
      zeroAbove[DIGITS-1] = (activeNext[4*(DIGITS-1) +: 4] == 4'h0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         zeroAbove[i] = zeroAbove[i+1] && (activeNext[4*i +: 4] == 4'h0);
      end
      suppress  = blankZeroIN && (idxNext != '0) && zeroAbove[idxNext];

      segNext   = SEG_OFF;
      dpNext    = SEG_ACTIVE_LOW;
      anodeNext = AN_OFF;
      if (stateNext == DRIVE) begin
         anodeNext[idxNext] = ~AN_ACTIVE_LOW;
         segNext            = (suppress ? 7'h00 : decodeHex(nibble)) ^ SEG_OFF;
         dpNext             = activeDpNext[idxNext] ^ SEG_ACTIVE_LOW;
      end
   end

   always_ff @(posedge clockIN or posedge resetIN) begin
      if (resetIN) begin
         state        <= BLANK;
         idx          <= '0;
         counter      <= BLANK_LOAD;
         activeValue  <= '0;
         activeDp     <= '0;
         pendingValue <= '0;
         pendingDp    <= '0;
         pendingOUT   <= 1'b0;
         frameOUT     <= 1'b0;
         segOUT       <= SEG_OFF;
         dpOUT        <= SEG_ACTIVE_LOW;
         anodeOUT     <= AN_OFF;
      end else begin
         state        <= stateNext;
         idx          <= idxNext;
         counter      <= counterNext;
         activeValue  <= activeNext;
         activeDp     <= activeDpNext;
         pendingValue <= pendingValueNext;
         pendingDp    <= pendingDpNext;
         pendingOUT   <= pendingNext;
         frameOUT     <= wrapTick;
         segOUT       <= segNext;
         dpOUT        <= dpNext;
         anodeOUT     <= anodeNext;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomised and directed bench for seven_seg_scan against a digit-level
// display model (value, shadow, scan position) kept in plain arithmetic.
module tb_seven_seg_scan;

   localparam int DIGITS = 4;
   localparam int BLANK  = 16;

   logic        clockIN = 1'b0;
   logic        resetIN;
   logic        scanClkIN;
   logic        loadIN;
   logic [15:0] valueIN;
   logic [3:0]  dpIN;
   logic        blankZeroIN;
   logic [6:0]  segOUT;
   logic        dpOUT;
   logic [3:0]  anodeOUT;
   logic        frameOUT;
   logic        pendingOUT;

   seven_seg_scan #(
      .DIGITS(DIGITS), .BLANK_CYCLES(BLANK), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clockIN(clockIN), .resetIN(resetIN), .scanClkIN(scanClkIN), .loadIN(loadIN),
      .valueIN(valueIN), .dpIN(dpIN), .blankZeroIN(blankZeroIN), .segOUT(segOUT),
      .dpOUT(dpOUT), .anodeOUT(anodeOUT), .frameOUT(frameOUT), .pendingOUT(pendingOUT)
   );

   always #5 clockIN = ~clockIN;

   int passCnt  = 0;
   int totalCnt = 0;

   // Display model: what the panel should show, not how the RTL sequences it.
   int          expIdx;
   logic [15:0] expActive, expPend;
   logic [3:0]  expActDp, expPendDp;
   bit          expPending;

   logic [6:0] segTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   function automatic logic [6:0] modelSeg(input int digit);
      int upper;
      upper = int'(expActive) >> (4 * digit);
      if (blankZeroIN && digit > 0 && upper == 0) return 7'h7F;
      return ~segTable[upper % 16];
   endfunction

   function automatic logic [3:0] modelAnode(input int digit);
      return ~(4'b0001 << digit);
   endfunction

   function automatic void modelReset();
      expIdx = 0; expActive = '0; expActDp = '0; expPend = '0; expPendDp = '0; expPending = 0;
   endfunction

   // Scan clock pulse; optional load lands on the same cycle the tick is taken.
   task automatic pulseScan(input bit loadAtTick, input logic [15:0] v, input logic [3:0] d);
      bit wrap;
      scanClkIN = 1'b1;
      @(negedge clockIN);
      @(negedge clockIN);
      if (loadAtTick) begin
         loadIN = 1'b1; valueIN = v; dpIN = d;
      end
      @(negedge clockIN);
      loadIN = 1'b0;
      scanClkIN = 1'b0;
      wrap = (expIdx == DIGITS - 1);
      expIdx = wrap ? 0 : expIdx + 1;
      if (wrap) begin
         if (loadAtTick) begin
            expActive = v; expActDp = d;
         end else if (expPending) begin
            expActive = expPend; expActDp = expPendDp;
         end
         expPending = 0;
      end else if (loadAtTick) begin
         expPend = v; expPendDp = d; expPending = 1;
      end
      totalCnt++;
      if (frameOUT !== wrap) $display("FAIL frame_at_tick: got %b want %b", frameOUT, wrap);
      else passCnt++;
      totalCnt++;
      if (anodeOUT !== 4'hF) $display("FAIL anode_off_at_tick: got %b want 1111", anodeOUT);
      else passCnt++;
   endtask

   // Count the blank gap from the current sample, then check the driven digit.
   task automatic observeDigit();
      int offCnt;
      offCnt = 0;
      for (int k = 0; k < 64 && anodeOUT === 4'hF; k++) begin
         offCnt++;
         @(negedge clockIN);
      end
      totalCnt++;
      if (offCnt != BLANK + 1) $display("FAIL blank_gap: got %0d cycles want %0d", offCnt, BLANK + 1);
      else passCnt++;
      totalCnt++;
      if (anodeOUT !== modelAnode(expIdx)) $display("FAIL anode_d%0d: got %b want %b", expIdx, anodeOUT, modelAnode(expIdx));
      else passCnt++;
      totalCnt++;
      if (segOUT !== modelSeg(expIdx)) $display("FAIL seg_d%0d: got %h want %h (active %h bz %b)", expIdx, segOUT, modelSeg(expIdx), expActive, blankZeroIN);
      else passCnt++;
      totalCnt++;
      if (dpOUT !== ~expActDp[expIdx]) $display("FAIL dp_d%0d: got %b want %b", expIdx, dpOUT, ~expActDp[expIdx]);
      else passCnt++;
      totalCnt++;
      if (pendingOUT !== expPending) $display("FAIL pending_d%0d: got %b want %b", expIdx, pendingOUT, expPending);
      else passCnt++;
   endtask

   task automatic stepDigit();
      pulseScan(1'b0, 16'h0, 4'h0);
      observeDigit();
   endtask

   task automatic advanceTo(input int target);
      while (expIdx != target) stepDigit();
   endtask

   task automatic loadPulse(input logic [15:0] v, input logic [3:0] d);
      loadIN = 1'b1; valueIN = v; dpIN = d;
      @(negedge clockIN);
      loadIN = 1'b0;
      expPend = v; expPendDp = d; expPending = 1;
      totalCnt++;
      if (pendingOUT !== 1'b1) $display("FAIL pending_after_load: got %b want 1", pendingOUT);
      else passCnt++;
   endtask

   task automatic test_reset();
      resetIN = 1'b1; scanClkIN = 1'b1; loadIN = 1'b0; valueIN = '0; dpIN = '0; blankZeroIN = 1'b0;
      modelReset();
      repeat (3) @(negedge clockIN);
      totalCnt++;
      if ({anodeOUT, segOUT, dpOUT, frameOUT, pendingOUT} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0})
         $display("FAIL reset_outputs: got an=%b seg=%h dp=%b fr=%b pend=%b want an=1111 seg=7f dp=1 fr=0 pend=0",
                  anodeOUT, segOUT, dpOUT, frameOUT, pendingOUT);
      else passCnt++;
      resetIN = 1'b0;
      @(negedge clockIN);
      totalCnt++;
      if (anodeOUT !== 4'hF) $display("FAIL release_anode: got %b want 1111", anodeOUT);
      else passCnt++;
      repeat (25) @(negedge clockIN);
      totalCnt++;
      if (anodeOUT !== 4'b1110) $display("FAIL no_tick_high_release: anode got %b want 1110", anodeOUT);
      else passCnt++;
      totalCnt++;
      if (segOUT !== modelSeg(0)) $display("FAIL reset_digit0_seg: got %h want %h", segOUT, modelSeg(0));
      else passCnt++;
      scanClkIN = 1'b0;
      repeat (4) @(negedge clockIN);
   endtask

   task automatic test_scan();
      loadPulse(16'h12AF, 4'h0);
      repeat (4) stepDigit();
      repeat (4) stepDigit();
   endtask

   task automatic test_gap_restart();
      pulseScan(1'b0, 16'h0, 4'h0);
      repeat (5) @(negedge clockIN);
      totalCnt++;
      if (anodeOUT !== 4'hF) $display("FAIL gap_mid_anode: got %b want 1111", anodeOUT);
      else passCnt++;
      pulseScan(1'b0, 16'h0, 4'h0);
      observeDigit();
   endtask

   task automatic test_load_shadow();
      advanceTo(1);
      loadPulse(16'h0005, 4'h0);
      advanceTo(0);
      advanceTo(3);
      pulseScan(1'b1, 16'hBEEF, 4'b0001);
      observeDigit();
      stepDigit();
   endtask

   task automatic test_zero_suppress();
      blankZeroIN = 1'b1;
      advanceTo(3);
      pulseScan(1'b1, 16'h0040, 4'b0100);
      observeDigit();
      repeat (3) stepDigit();
      blankZeroIN = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] v;
      logic [3:0]  d;
      for (int n = 0; n < 8; n++) begin
         v = 16'($urandom) >> (4 * $urandom_range(0, 3));
         d = 4'($urandom);
         blankZeroIN = 1'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            advanceTo(3);
            pulseScan(1'b1, v, d);
            observeDigit();
         end else begin
            advanceTo($urandom_range(0, 2));
            loadPulse(v, d);
         end
         repeat (4) stepDigit();
      end
      blankZeroIN = 1'b0;
   endtask

   task automatic test_reset_mid();
      advanceTo(2);
      resetIN = 1'b1;
      #1;
      totalCnt++;
      if (anodeOUT !== 4'hF || segOUT !== 7'h7F) $display("FAIL async_reset: got an=%b seg=%h want an=1111 seg=7f", anodeOUT, segOUT);
      else passCnt++;
      modelReset();
      @(negedge clockIN);
      @(negedge clockIN);
      resetIN = 1'b0;
      observeDigit();
      repeat (2) stepDigit();
   endtask

   initial begin
      test_reset();
      test_scan();
      test_gap_restart();
      test_load_shadow();
      test_zero_suppress();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
